sv_pla_table_pipe: RTL

//  Parametrised, run-time programmable lookup table with a registered, valid/ready output stage.

---
 rtl/sv_pla_table_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sv_pla_table_pipe.sv
// Run-time programmable lookup table with a registered valid/ready output stage.
// After reset the table is cleared to DEFAULT_VAL one entry per cycle (INIT),
// then it serves lookups and accepts config writes (RUN) until the next reset.
//
// Handshake semantics: a transfer happens on a rising edge where valid and ready
// are both high. A producer holds valid and its payload stable until the transfer.
// in_ready depends only on state, out_valid and out_ready, never on in_valid.
module sv_pla_table_pipe #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 1,
  parameter int DEPTH       = 81,
  parameter int DEFAULT_VAL = 1,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              init_busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  oor_count
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] DEF_C    = DATA_W'(DEFAULT_VAL);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range;
  logic                cfg_in_range;
  logic                cfg_wr;
  logic                accept;
  logic [DATA_W-1:0]   lookup_data;

  // Address decode, handshake and write-first read mux.
  always_comb begin
    in_range     = ({1'b0, in_addr} < DEPTH_C);
    cfg_in_range = ({1'b0, cfg_addr} < DEPTH_C);
    cfg_wr       = (state == ST_RUN) & cfg_we & cfg_in_range;
    in_ready     = (state == ST_RUN) & (~out_valid | out_ready);
    accept       = in_valid & in_ready;
    lookup_data  = DEF_C;
    if (in_range) begin
      if (cfg_wr && (cfg_addr == in_addr)) begin
        lookup_data = cfg_data;
      end else begin
        lookup_data = mem[in_addr];
      end
    end
  end

  // Sequencer: sweep every entry once after reset, then stay in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      idx       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          init_busy <= 1'b0;
        end
        default: begin
          state     <= ST_INIT;
          idx       <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Table storage: cleared by the INIT sweep, programmed by config writes in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[idx] <= DEF_C;
      end else if (cfg_wr) begin
        mem[cfg_addr] <= cfg_data;
      end
    end
  end

  // Output register: load on accept, clear on drain, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= DEF_C;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lookup_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of accepted lookups that fall outside the table.
  always_ff @(posedge clk) begin
    if (reset) begin
      oor_count <= '0;
    end else if (accept && !in_range && (oor_count != '1)) begin
      oor_count <= oor_count + 1'b1;
    end
  end

endmodule
